// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: arbitrates fetch and load/store requests onto the SQI bus
// and runs each grant as one complete SQI transaction on the selected chip.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and grant
// CMD   | two command nibbles, 0x03 read / 0x02 write
// ADDR  | six byte-address nibbles, MSB first
// DUMMY | read turnaround nibbles, bus released
// DATA  | four data nibbles, driven on write, sampled on read
// DONE  | all CS high; read data returned to its requester
//
// The state register runs one cycle ahead of the pins: every output is a
// register loaded from the current state, so a state is visible on the pins
// in the cycle after it is held. Each nibble state counts down from an odd
// value, so an odd count is phase 0 (SCK low) and an even count is phase 1.
module idli_mem_arb_m #(
    parameter int ADDR_W    = 16,
    parameter int CHIP_NUM  = 2,
    parameter int DUMMY_NIB = 2
) (
    input  logic                i_mem_gck,
    input  logic                i_mem_rst_n,
    input  logic                i_mem_f_req,
    input  logic [ADDR_W-1:0]   i_mem_f_addr,
    output logic                o_mem_f_ack,
    output logic                o_mem_f_rvalid,
    output logic [15:0]         o_mem_f_rdata,
    input  logic                i_mem_d_req,
    input  logic                i_mem_d_wr,
    input  logic [ADDR_W-1:0]   i_mem_d_addr,
    input  logic [15:0]         i_mem_d_wdata,
    output logic                o_mem_d_ack,
    output logic                o_mem_d_rvalid,
    output logic [15:0]         o_mem_d_rdata,
    output logic [CHIP_NUM-1:0] o_mem_sck,
    output logic [CHIP_NUM-1:0] o_mem_cs,
    output logic                o_mem_sio_oe,
    output logic [3:0]          o_mem_sio,
    input  logic [3:0]          i_mem_sio
);
    localparam int CS_W  = $clog2(CHIP_NUM);
    localparam int LO_W  = ADDR_W - CS_W;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase1;
    logic                last_d_q;
    logic                srv_d_q;
    logic                wr_q;
    logic [CS_W-1:0]     chip_q;
    logic [47:0]         tx_q;
    logic [11:0]         rx_q;
    logic                smp_q, smp_d;
    logic                grant_f, grant_d;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [23:0]         gnt_byte;
    logic [CHIP_NUM-1:0] chip_mask;

    logic [CHIP_NUM-1:0] cs_d, sck_d;
    logic                oe_d;
    logic [3:0]          sio_d;
    logic                f_ack_d, d_ack_d, f_rvalid_d, d_rvalid_d;
    logic [15:0]         f_rdata_d, d_rdata_d;

    // last_d_q = 1 means data was served last, so fetch wins a tie
    assign grant_f   = (state_q == ST_IDLE) && i_mem_f_req && (!i_mem_d_req || last_d_q);
    assign grant_d   = (state_q == ST_IDLE) && i_mem_d_req && (!i_mem_f_req || !last_d_q);
    assign gnt_addr  = grant_d ? i_mem_d_addr : i_mem_f_addr;
    assign gnt_byte  = 24'({gnt_addr[LO_W-1:0], 1'b0});
    assign chip_mask = CHIP_NUM'(1) << chip_q;
    assign phase1    = ~cnt_q[0];

    // state register and nibble down-counter
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: each nibble state ends when its counter reaches zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (grant_f || grant_d) begin
                    state_d = ST_CMD;
                    cnt_d   = CNT_W'(3);
                end
            end
            ST_CMD: if (cnt_q == '0) begin
                state_d = ST_ADDR;
                cnt_d   = CNT_W'(11);
            end
            ST_ADDR: if (cnt_q == '0) begin
                if (wr_q || DUMMY_NIB == 0) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'(7);
                end else begin
                    state_d = ST_DUMMY;
                    cnt_d   = CNT_W'(2 * DUMMY_NIB - 1);
                end
            end
            ST_DUMMY: if (cnt_q == '0) begin
                state_d = ST_DATA;
                cnt_d   = CNT_W'(7);
            end
            ST_DATA: if (cnt_q == '0) begin
                state_d = ST_DONE;
                cnt_d   = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // pin and handshake values for the next cycle, derived from the current state
    always_comb begin
        cs_d       = '1;
        sck_d      = '0;
        oe_d       = 1'b0;
        sio_d      = 4'h0;
        f_ack_d    = grant_f;
        d_ack_d    = grant_d;
        f_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        f_rdata_d  = o_mem_f_rdata;
        d_rdata_d  = o_mem_d_rdata;
        smp_d      = 1'b0;
        case (state_q)
            ST_CMD, ST_ADDR: begin
                cs_d  = ~chip_mask;
                sck_d = phase1 ? chip_mask : '0;
                oe_d  = 1'b1;
                sio_d = tx_q[47:44];
            end
            ST_DUMMY: begin
                cs_d  = ~chip_mask;
                sck_d = phase1 ? chip_mask : '0;
            end
            ST_DATA: begin
                cs_d  = ~chip_mask;
                sck_d = phase1 ? chip_mask : '0;
                oe_d  = wr_q;
                sio_d = wr_q ? tx_q[47:44] : 4'h0;
                smp_d = !wr_q && phase1;
            end
            ST_DONE: begin
                // last nibble is taken straight from the pins on this edge
                if (!wr_q) begin
                    if (srv_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = {rx_q, i_mem_sio};
                    end else begin
                        f_rvalid_d = 1'b1;
                        f_rdata_d  = {rx_q, i_mem_sio};
                    end
                end
            end
            default: ;
        endcase
    end

    // registered outputs, grant capture and the nibble shift registers
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            o_mem_cs       <= '1;
            o_mem_sck      <= '0;
            o_mem_sio_oe   <= 1'b0;
            o_mem_sio      <= 4'h0;
            o_mem_f_ack    <= 1'b0;
            o_mem_d_ack    <= 1'b0;
            o_mem_f_rvalid <= 1'b0;
            o_mem_d_rvalid <= 1'b0;
            o_mem_f_rdata  <= 16'h0;
            o_mem_d_rdata  <= 16'h0;
            last_d_q       <= 1'b1;
            srv_d_q        <= 1'b0;
            wr_q           <= 1'b0;
            chip_q         <= '0;
            tx_q           <= '0;
            rx_q           <= '0;
            smp_q          <= 1'b0;
        end else begin
            o_mem_cs       <= cs_d;
            o_mem_sck      <= sck_d;
            o_mem_sio_oe   <= oe_d;
            o_mem_sio      <= sio_d;
            o_mem_f_ack    <= f_ack_d;
            o_mem_d_ack    <= d_ack_d;
            o_mem_f_rvalid <= f_rvalid_d;
            o_mem_d_rvalid <= d_rvalid_d;
            o_mem_f_rdata  <= f_rdata_d;
            o_mem_d_rdata  <= d_rdata_d;
            smp_q          <= smp_d;
            if (grant_f || grant_d) begin
                last_d_q <= grant_d;
                srv_d_q  <= grant_d;
                wr_q     <= grant_d && i_mem_d_wr;
                chip_q   <= gnt_addr[ADDR_W-1 -: CS_W];
                tx_q     <= {(grant_d && i_mem_d_wr) ? 8'h02 : 8'h03, gnt_byte, i_mem_d_wdata};
            end else if (phase1 && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA)) begin
                tx_q <= {tx_q[43:0], 4'h0};
            end
            if (smp_q) begin
                rx_q <= {rx_q[7:0], i_mem_sio};
            end
        end
    end

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Testbench for idli_mem_arb_m: directed scenarios followed by randomized
// transactions, each checked cycle by cycle against a transaction-level model.
module tb_idli_mem_arb_m;
    localparam int ADDR_W    = 16;
    localparam int CHIP_NUM  = 2;
    localparam int DUMMY_NIB = 2;
    localparam int CS_W      = $clog2(CHIP_NUM);
    localparam int LO_W      = ADDR_W - CS_W;

    logic                clk;
    logic                rst_n;
    logic                f_req, d_req, d_wr;
    logic [ADDR_W-1:0]   f_addr, d_addr;
    logic [15:0]         d_wdata;
    logic [3:0]          sio_in;
    logic                f_ack, f_rvalid, d_ack, d_rvalid;
    logic [15:0]         f_rdata, d_rdata;
    logic [CHIP_NUM-1:0] sck, cs;
    logic                oe;
    logic [3:0]          sio;

    int          checks;
    int          failures;
    logic [15:0] mdl_f_rdata, mdl_d_rdata;
    bit          last_d;

    idli_mem_arb_m #(.ADDR_W(ADDR_W), .CHIP_NUM(CHIP_NUM), .DUMMY_NIB(DUMMY_NIB)) dut (
        .i_mem_gck(clk), .i_mem_rst_n(rst_n),
        .i_mem_f_req(f_req), .i_mem_f_addr(f_addr), .o_mem_f_ack(f_ack),
        .o_mem_f_rvalid(f_rvalid), .o_mem_f_rdata(f_rdata),
        .i_mem_d_req(d_req), .i_mem_d_wr(d_wr), .i_mem_d_addr(d_addr),
        .i_mem_d_wdata(d_wdata), .o_mem_d_ack(d_ack),
        .o_mem_d_rvalid(d_rvalid), .o_mem_d_rdata(d_rdata),
        .o_mem_sck(sck), .o_mem_cs(cs), .o_mem_sio_oe(oe),
        .o_mem_sio(sio), .i_mem_sio(sio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle after requests are presented: the model picks the winner
    // (lone requester, or on a tie whoever was not served last).
    task automatic grant_step(input bit f_on, input bit d_on, output bit got_d);
        bit exp_d;
        @(negedge clk);
        if (f_on && d_on) exp_d = !last_d;
        else              exp_d = d_on;
        chk("f_ack", f_ack, !exp_d);
        chk("d_ack", d_ack, exp_d);
        last_d = exp_d;
        got_d  = exp_d;
    endtask

    // Called at the negedge of the ack cycle (cycle 0). Checks cycles 1..DONE,
    // plays the SQI chip on reads (junk in phase 0, real nibble in phase 1).
    // abort_cyc > 0 asserts reset in that cycle; oth_cyc > 0 raises the
    // other requester's req in that cycle.
    task automatic expect_txn(input bit is_f, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rword,
                              input int abort_cyc, input int oth_cyc);
        logic [3:0]          nib [16];
        bit                  oe_e [16];
        logic [23:0]         ba;
        logic [7:0]          cmd;
        logic [CHIP_NUM-1:0] sel, e_cs, e_sck, all1;
        int                  nn, chip, k, ph;
        all1 = '1;
        ba   = (24'(addr) & ((24'd1 << LO_W) - 24'd1)) << 1;
        chip = int'(addr) >> LO_W;
        sel  = CHIP_NUM'(1) << chip;
        e_cs = ~sel;
        cmd  = wr ? 8'h02 : 8'h03;
        nn   = 0;
        for (int i = 0; i < 2; i++) begin nib[nn] = cmd[7-4*i -: 4]; oe_e[nn] = 1'b1; nn++; end
        for (int i = 0; i < 6; i++) begin nib[nn] = ba[23-4*i -: 4]; oe_e[nn] = 1'b1; nn++; end
        if (!wr) for (int i = 0; i < DUMMY_NIB; i++) begin nib[nn] = 4'h0; oe_e[nn] = 1'b0; nn++; end
        for (int i = 0; i < 4; i++) begin
            nib[nn]  = wr ? wdata[15-4*i -: 4] : rword[15-4*i -: 4];
            oe_e[nn] = wr;
            nn++;
        end
        for (int c = 1; c <= 2 * nn; c++) begin
            @(negedge clk);
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("abort_cs", cs, all1);
                chk("abort_sck", sck, 0);
                chk("abort_oe", oe, 0);
                return;
            end
            if (c == oth_cyc) begin
                if (is_f) d_req = 1'b1;
                else      f_req = 1'b1;
            end
            k = (c - 1) / 2;
            ph = (c - 1) % 2;
            sio_in = (!wr && k >= nn - 4 && ph == 1) ? nib[k] : 4'($urandom);
            e_sck = (ph == 1) ? sel : '0;
            chk($sformatf("cs c%0d", c), cs, e_cs);
            chk($sformatf("sck c%0d", c), sck, e_sck);
            chk($sformatf("oe c%0d", c), oe, oe_e[k]);
            if (oe_e[k]) chk($sformatf("sio c%0d", c), sio, nib[k]);
            chk($sformatf("busy acks/rvalids c%0d", c), {f_ack, d_ack, f_rvalid, d_rvalid}, 0);
        end
        @(negedge clk);
        if (!wr) begin
            if (is_f) mdl_f_rdata = rword;
            else      mdl_d_rdata = rword;
        end
        chk("done_cs", cs, all1);
        chk("done_sck_oe", {sck, oe}, 0);
        chk("done_f_rvalid", f_rvalid, is_f && !wr);
        chk("done_d_rvalid", d_rvalid, !is_f && !wr);
        chk("done_f_rdata", f_rdata, mdl_f_rdata);
        chk("done_d_rdata", d_rdata, mdl_d_rdata);
    endtask

    initial begin
        bit          gd, seen, fo, dn;
        logic [15:0] rw;
        logic [CHIP_NUM-1:0] all1;
        all1 = '1;
        checks = 0; failures = 0;
        mdl_f_rdata = 16'h0; mdl_d_rdata = 16'h0; last_d = 1'b1;
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; sio_in = 4'h0;

        repeat (3) @(negedge clk);
        chk("rst_cs", cs, all1);
        chk("rst_sck", sck, 0);
        chk("rst_oe_sio", {oe, sio}, 0);
        chk("rst_acks_rvalids", {f_ack, d_ack, f_rvalid, d_rvalid}, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // both requesting straight after reset: fetch read first, data write at cycle 30
        f_addr = 16'h0010; d_addr = 16'h8004; d_wr = 1'b1; d_wdata = 16'h1234;
        f_req = 1'b1; d_req = 1'b1;
        grant_step(1'b1, 1'b1, gd);
        f_req = 1'b0;
        expect_txn(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, -1, -1);
        grant_step(1'b0, 1'b1, gd);
        d_req = 1'b0;

        // write on chip 1; fetch raised mid-write must be acked at cycle 26
        f_addr = 16'h0ABC;
        expect_txn(1'b0, 1'b1, 16'h8004, 16'h1234, 16'h0, -1, 10);
        grant_step(1'b1, 1'b0, gd);
        f_req = 1'b0;

        // data read raised during a fetch: no ack until the fetch ends
        d_addr = 16'h0123; d_wr = 1'b0;
        expect_txn(1'b1, 1'b0, 16'h0ABC, 16'h0, 16'h5A3C, -1, 5);
        grant_step(1'b0, 1'b1, gd);
        d_req = 1'b0;
        expect_txn(1'b0, 1'b0, 16'h0123, 16'h0, 16'hC0DE, -1, -1);

        // both held: grants alternate
        f_addr = 16'h7FFE; d_addr = 16'hFFFF; d_wr = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rw = 16'($urandom);
            grant_step(1'b1, 1'b1, gd);
            if (i == 3) begin f_req = 1'b0; d_req = 1'b0; end
            expect_txn(!gd, 1'b0, gd ? d_addr : f_addr, 16'h0, rw, -1, -1);
        end

        // reset in cycle 12 of a read abandons it
        f_addr = 16'h4321; f_req = 1'b1;
        grant_step(1'b1, 1'b0, gd);
        f_req = 1'b0;
        expect_txn(1'b1, 1'b0, 16'h4321, 16'h0, 16'h1111, 12, -1);
        mdl_f_rdata = 16'h0; mdl_d_rdata = 16'h0; last_d = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (f_rvalid || d_rvalid || cs !== all1) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_f_rdata", f_rdata, 0);

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            fo = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            if (!fo && !dn) fo = 1'b1;
            f_addr = 16'($urandom); d_addr = 16'($urandom);
            d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
            rw = 16'($urandom);
            f_req = fo; d_req = dn;
            grant_step(fo, dn, gd);
            f_req = 1'b0; d_req = 1'b0;
            expect_txn(!gd, gd && d_wr, gd ? d_addr : f_addr, d_wdata, rw, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
